ramb_tdp_sync: RTL and testbench
================================

// Module: ramb_tdp_sync
// PURPOSE
//  Parametrised, synthesisable single-clock true-dual-port RAM. Successor to the fixed
//  36Kb block-RAM primitive: generic width/depth, per-byte write enables, per-port
//  write mode, optional output pipeline register, defined collision policy,
//  reset-time memory clear. Used by array wrappers needing portable TDP storage.
// PARAMETERS
//  DATA_WIDTH     36             word width; must be a multiple of BYTE_WIDTH (elab error otherwise)
//  BYTE_WIDTH     9              bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH
//  ADDR_WIDTH     10             address bits; DEPTH = 2**ADDR_WIDTH
//  WRITE_MODE_A   "WRITE_FIRST"  "WRITE_FIRST" | "READ_FIRST" | "NO_CHANGE"
//  WRITE_MODE_B   "WRITE_FIRST"  as WRITE_MODE_A, for port B
//  DO_REG         0              0: read latency 1; 1: latency 2 via output register
//  CLEAR_ON_RST   1              1: rst triggers sequential clear of all words to INIT_VAL
//  INIT_VAL       0              DATA_WIDTH-bit clear value
// PORTS
//  clk        in   1            single clock, all ports
//  rst        in   1            synchronous, active-high reset
//  init_busy  out  1            1 while clear sequence runs; port accesses ignored
//  ena        in   1            port A enable (read and/or write)
//  wea        in   NB           port A byte write enables
//  addra      in   ADDR_WIDTH   port A address
//  dia        in   DATA_WIDTH   port A write data
//  regcea     in   1            port A output-register clock enable (DO_REG=1 only)
//  doa        out  DATA_WIDTH   port A read data
//  enb        in   1            port B enable
//  web        in   NB           port B byte write enables
//  addrb      in   ADDR_WIDTH   port B address
//  dib        in   DATA_WIDTH   port B write data
//  regceb     in   1            port B output-register clock enable
//  dob        out  DATA_WIDTH   port B read data
//  collision  out  1            registered flag: same-address conflict occurred
// BEHAVIOUR
//  - Reset: doa, dob, both pipeline stages, collision = 0. CLEAR_ON_RST=1: FSM -> CLEAR,
//    counter = 0, init_busy = 1 from the cycle after rst asserts. CLEAR_ON_RST=0: FSM -> RUN.
//  - FSM CLEAR: each cycle write INIT_VAL at counter, counter++; after DEPTH-1 written,
//    -> RUN next cycle (init_busy=0 exactly DEPTH cycles after rst deasserts). rst
//    mid-clear restarts counter at 0. ena/enb forced low internally in CLEAR; doa/dob hold 0.
//  - FSM RUN: normal access. Counter wraps cleanly at DEPTH; no extra states.
//  - Read: ena=1 at edge N -> stage-1 data valid after edge N. DO_REG=0: doa = stage 1
//    (latency 1). DO_REG=1: doa loads stage 1 at edge N+1 if regcea=1, else holds (latency 2).
//    ena=0: stage 1 holds last value.
//  - Write: byte i of mem[addra] <= dia[i*BW+:BW] when ena & wea[i]. Stage-1 on write:
//    WRITE_FIRST = new word (written bytes new, rest old); READ_FIRST = old word;
//    NO_CHANGE = stage 1 holds. Port B identical with B signals/mode.
//  - Collision (ena & enb & addra==addrb & (|wea | |web)):
//    both write: per byte, port A wins if wea[i], else port B's byte;
//    read port (no write) returns old word (READ_FIRST semantics regardless of mode);
//    writing port returns per its own mode using the final merged word.
//    collision = 1 for one cycle, registered, aligned with stage-1 data; 0 otherwise.
//  - Read/read same address: no collision, both return stored word.
//  - Widths: addresses unsigned, no out-of-range possible; no X ever driven on outputs.
// TESTING
//  - Clear: DEPTH=16, INIT_VAL=0x5A, rst 1 cycle -> init_busy high 16 cycles; read all -> 0x5A.
//  - rst asserted at clear count 7 -> counter restarts, init_busy high 16 more cycles.
//  - Modes: mem[3]=0x111; A writes 0x222 to 3 -> doa = 0x222 / 0x111 / prior doa for
//    WRITE_FIRST / READ_FIRST / NO_CHANGE; mem[3] = 0x222 in all.
//  - Byte enables: NB=4, BW=9, word 0, wea=4'b0101, dia all-ones -> bytes 0,2 set, 1,3 kept.
//  - Collision: A writes 0xAAA, B writes 0xBBB to addr 5, wea=web=all -> mem[5]=0xAAA,
//    collision=1 one cycle; A writes, B reads same addr -> dob=old, collision=1.
//  - DO_REG=1: read addr 2 with regcea=0 next cycle -> doa unchanged; regcea=1 -> data at +2.

Source files
------------

// File: rtl/ramb_tdp_sync.sv
// ramb_tdp_sync: single-clock true-dual-port RAM with byte write enables,
// per-port write mode, optional output register, a fixed collision policy
// and a sequential memory clear after reset.
module ramb_tdp_sync #(
   parameter int unsigned           DATA_WIDTH   = 36,
   parameter int unsigned           BYTE_WIDTH   = 9,
   parameter int unsigned           ADDR_WIDTH   = 10,
   parameter string                 WRITE_MODE_A = "WRITE_FIRST",
   parameter string                 WRITE_MODE_B = "WRITE_FIRST",
   parameter int                    DO_REG       = 0,
   parameter int                    CLEAR_ON_RST = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VAL     = '0
) (
   input  logic                                clk,
   input  logic                                rst,
   output logic                                init_busy,
   input  logic                                ena,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    wea,
   input  logic [ADDR_WIDTH-1:0]               addra,
   input  logic [DATA_WIDTH-1:0]               dia,
   input  logic                                regcea,
   output logic [DATA_WIDTH-1:0]               doa,
   input  logic                                enb,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    web,
   input  logic [ADDR_WIDTH-1:0]               addrb,
   input  logic [DATA_WIDTH-1:0]               dib,
   input  logic                                regceb,
   output logic [DATA_WIDTH-1:0]               dob,
   output logic                                collision
);

   localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH;
   localparam int unsigned BW    = BYTE_WIDTH;
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {ST_RUN, ST_CLEAR} state_t;
   typedef enum logic [1:0] {WM_WRITE_FIRST, WM_READ_FIRST, WM_NO_CHANGE} wmode_t;

   localparam wmode_t MODE_A = (WRITE_MODE_A == "READ_FIRST") ? WM_READ_FIRST :
                               (WRITE_MODE_A == "NO_CHANGE")  ? WM_NO_CHANGE  : WM_WRITE_FIRST;
   localparam wmode_t MODE_B = (WRITE_MODE_B == "READ_FIRST") ? WM_READ_FIRST :
                               (WRITE_MODE_B == "NO_CHANGE")  ? WM_NO_CHANGE  : WM_WRITE_FIRST;

   // Reject configurations that cannot be built consistently.
   if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
      $error("ramb_tdp_sync: DATA_WIDTH must be a multiple of BYTE_WIDTH");
   end
   if (WRITE_MODE_A != "WRITE_FIRST" && WRITE_MODE_A != "READ_FIRST" &&
       WRITE_MODE_A != "NO_CHANGE") begin : g_bad_mode_a
      $error("ramb_tdp_sync: unknown WRITE_MODE_A");
   end
   if (WRITE_MODE_B != "WRITE_FIRST" && WRITE_MODE_B != "READ_FIRST" &&
       WRITE_MODE_B != "NO_CHANGE") begin : g_bad_mode_b
      $error("ramb_tdp_sync: unknown WRITE_MODE_B");
   end

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   state_t                state, state_d;
   logic [ADDR_WIDTH-1:0] cnt, cnt_d;
   logic                  clr_we;
   logic                  run;

   logic                  a_en, b_en, a_wr, b_wr, same_addr;
   logic [NB-1:0]         a_we, b_we;
   logic [DATA_WIDTH-1:0] rd_a, rd_b, new_a, new_b;
   logic [DATA_WIDTH-1:0] q1a, q1b, q2a, q2b;
   logic                  col_q;

   // Port accesses are only honoured in RUN and outside reset.
   assign run       = (state == ST_RUN) && !rst;
   assign a_en      = ena && run;
   assign b_en      = enb && run;
   assign a_we      = wea & {NB{a_en}};
   assign b_we      = web & {NB{b_en}};
   assign a_wr      = |a_we;
   assign b_wr      = |b_we;
   assign same_addr = (addra == addrb);

   assign init_busy = (state == ST_CLEAR);
   assign doa       = (DO_REG != 0) ? q2a : q1a;
   assign dob       = (DO_REG != 0) ? q2b : q1b;
   assign collision = col_q;

   // FSM state and clear-counter register; reset restarts the clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   // Next-state logic: step through every address once, then run.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      clr_we  = 1'b0;
      case (state)
         ST_CLEAR: begin
            clr_we = !rst;
            cnt_d  = cnt + 1'b1;
            if (cnt == '1) state_d = ST_RUN;
         end
         default: ;
      endcase
   end

   // Old words and the final merged word as seen from each port
   // (port A bytes take priority over port B bytes on a shared address).
   always_comb begin
      rd_a  = mem[addra];
      rd_b  = mem[addrb];
      new_a = rd_a;
      new_b = rd_b;
      for (int unsigned i = 0; i < NB; i++) begin
         if (same_addr && b_we[i]) new_a[i*BW +: BW] = dib[i*BW +: BW];
         if (a_we[i])              new_a[i*BW +: BW] = dia[i*BW +: BW];
         if (b_we[i])              new_b[i*BW +: BW] = dib[i*BW +: BW];
         if (same_addr && a_we[i]) new_b[i*BW +: BW] = dia[i*BW +: BW];
      end
   end

   // Memory array: clear writes, else byte writes with port A issued last so it wins.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[cnt] <= INIT_VAL;
      end else begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (b_we[i]) mem[addrb][i*BW +: BW] <= dib[i*BW +: BW];
         end
         for (int unsigned i = 0; i < NB; i++) begin
            if (a_we[i]) mem[addra][i*BW +: BW] <= dia[i*BW +: BW];
         end
      end
   end

   // Port A stage-1 read data; a reading port always sees the old word.
   always_ff @(posedge clk) begin
      if (rst) begin
         q1a <= '0;
      end else if (a_en) begin
         if (a_wr) begin
            case (MODE_A)
               WM_WRITE_FIRST: q1a <= new_a;
               WM_READ_FIRST:  q1a <= rd_a;
               default:        ;
            endcase
         end else begin
            q1a <= rd_a;
         end
      end
   end

   // Port B stage-1 read data.
   always_ff @(posedge clk) begin
      if (rst) begin
         q1b <= '0;
      end else if (b_en) begin
         if (b_wr) begin
            case (MODE_B)
               WM_WRITE_FIRST: q1b <= new_b;
               WM_READ_FIRST:  q1b <= rd_b;
               default:        ;
            endcase
         end else begin
            q1b <= rd_b;
         end
      end
   end

   // Optional output registers, gated by their clock enables.
   always_ff @(posedge clk) begin
      if (rst) begin
         q2a <= '0;
         q2b <= '0;
      end else begin
         if (regcea && run) q2a <= q1a;
         if (regceb && run) q2b <= q1b;
      end
   end

   // Collision flag, aligned with the stage-1 data of the conflicting access.
   always_ff @(posedge clk) begin
      if (rst) col_q <= 1'b0;
      else     col_q <= a_en && b_en && same_addr && (a_wr || b_wr);
   end

endmodule

// File: tb/tb_ramb_tdp_sync.sv
// tb_ramb_tdp_sync: directed vector bench for ramb_tdp_sync; four instances
// share the stimulus and differ in port A write mode and output register.
module tb_ramb_tdp_sync;

   localparam int DW = 36;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          ena, enb, regcea, regceb;
   logic [3:0]    wea, web;
   logic [AW-1:0] addra, addrb;
   logic [DW-1:0] dia, dib;

   logic [DW-1:0] doa_w [4];
   logic [DW-1:0] dob_w [4];
   logic          busy_w [4];
   logic          col_w [4];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ramb_tdp_sync #(.DATA_WIDTH(DW), .BYTE_WIDTH(9), .ADDR_WIDTH(AW),
      .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("WRITE_FIRST"),
      .DO_REG(0), .CLEAR_ON_RST(1), .INIT_VAL(36'h05A)) u_wf (
      .clk(clk), .rst(rst), .init_busy(busy_w[0]),
      .ena(ena), .wea(wea), .addra(addra), .dia(dia), .regcea(regcea), .doa(doa_w[0]),
      .enb(enb), .web(web), .addrb(addrb), .dib(dib), .regceb(regceb), .dob(dob_w[0]),
      .collision(col_w[0]));

   ramb_tdp_sync #(.DATA_WIDTH(DW), .BYTE_WIDTH(9), .ADDR_WIDTH(AW),
      .WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("WRITE_FIRST"),
      .DO_REG(0), .CLEAR_ON_RST(1), .INIT_VAL(36'h05A)) u_rf (
      .clk(clk), .rst(rst), .init_busy(busy_w[1]),
      .ena(ena), .wea(wea), .addra(addra), .dia(dia), .regcea(regcea), .doa(doa_w[1]),
      .enb(enb), .web(web), .addrb(addrb), .dib(dib), .regceb(regceb), .dob(dob_w[1]),
      .collision(col_w[1]));

   ramb_tdp_sync #(.DATA_WIDTH(DW), .BYTE_WIDTH(9), .ADDR_WIDTH(AW),
      .WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("WRITE_FIRST"),
      .DO_REG(0), .CLEAR_ON_RST(1), .INIT_VAL(36'h05A)) u_nc (
      .clk(clk), .rst(rst), .init_busy(busy_w[2]),
      .ena(ena), .wea(wea), .addra(addra), .dia(dia), .regcea(regcea), .doa(doa_w[2]),
      .enb(enb), .web(web), .addrb(addrb), .dib(dib), .regceb(regceb), .dob(dob_w[2]),
      .collision(col_w[2]));

   ramb_tdp_sync #(.DATA_WIDTH(DW), .BYTE_WIDTH(9), .ADDR_WIDTH(AW),
      .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("WRITE_FIRST"),
      .DO_REG(1), .CLEAR_ON_RST(1), .INIT_VAL(36'h05A)) u_reg (
      .clk(clk), .rst(rst), .init_busy(busy_w[3]),
      .ena(ena), .wea(wea), .addra(addra), .dia(dia), .regcea(regcea), .doa(doa_w[3]),
      .enb(enb), .web(web), .addrb(addrb), .dib(dib), .regceb(regceb), .dob(dob_w[3]),
      .collision(col_w[3]));

   typedef struct {
      logic          ena;
      logic [3:0]    wea;
      logic [AW-1:0] addra;
      logic [DW-1:0] dia;
      logic          enb;
      logic [3:0]    web;
      logic [AW-1:0] addrb;
      logic [DW-1:0] dib;
      logic [DW-1:0] exp_wf;
      logic [DW-1:0] exp_rf;
      logic [DW-1:0] exp_nc;
      logic [DW-1:0] exp_dob;
      logic          exp_col;
   } vec_t;

   vec_t vt [15];

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy_w[0] && n < 40) begin
         n++;
         tick();
      end
   endtask

   int nb;

   initial begin
      //          ena  wea    aa     dia          enb  web    ab     dib           wf            rf            nc            dob           col
      vt[0]  = '{1'b1, 4'hF, 4'd3, 36'h111,       1'b0, 4'h0, 4'd0, 36'h0,        36'h111,      36'h05A,      36'h05A,      36'h05A,      1'b0};
      vt[1]  = '{1'b1, 4'hF, 4'd7, 36'h777,       1'b0, 4'h0, 4'd0, 36'h0,        36'h777,      36'h05A,      36'h05A,      36'h05A,      1'b0};
      vt[2]  = '{1'b1, 4'h0, 4'd7, 36'h0,         1'b0, 4'h0, 4'd0, 36'h0,        36'h777,      36'h777,      36'h777,      36'h05A,      1'b0};
      vt[3]  = '{1'b1, 4'hF, 4'd3, 36'h222,       1'b0, 4'h0, 4'd0, 36'h0,        36'h222,      36'h111,      36'h777,      36'h05A,      1'b0};
      vt[4]  = '{1'b1, 4'h0, 4'd3, 36'h0,         1'b0, 4'h0, 4'd0, 36'h0,        36'h222,      36'h222,      36'h222,      36'h05A,      1'b0};
      vt[5]  = '{1'b1, 4'h5, 4'd0, 36'hFFFFFFFFF, 1'b0, 4'h0, 4'd0, 36'h0,        36'h007FC01FF, 36'h05A,     36'h222,      36'h05A,      1'b0};
      vt[6]  = '{1'b1, 4'h0, 4'd0, 36'h0,         1'b1, 4'h0, 4'd3, 36'h0,        36'h007FC01FF, 36'h007FC01FF, 36'h007FC01FF, 36'h222,   1'b0};
      vt[7]  = '{1'b1, 4'hF, 4'd5, 36'hAAA,       1'b1, 4'hF, 4'd5, 36'hBBB,      36'hAAA,      36'h05A,      36'h007FC01FF, 36'hAAA,     1'b1};
      vt[8]  = '{1'b1, 4'h0, 4'd5, 36'h0,         1'b1, 4'h0, 4'd5, 36'h0,        36'hAAA,      36'hAAA,      36'hAAA,      36'hAAA,      1'b0};
      vt[9]  = '{1'b1, 4'hF, 4'd5, 36'hCCC,       1'b1, 4'h0, 4'd5, 36'h0,        36'hCCC,      36'hAAA,      36'hAAA,      36'hAAA,      1'b1};
      vt[10] = '{1'b1, 4'h0, 4'd5, 36'h0,         1'b1, 4'h0, 4'd5, 36'h0,        36'hCCC,      36'hCCC,      36'hCCC,      36'hCCC,      1'b0};
      vt[11] = '{1'b1, 4'h3, 4'd6, 36'h0,         1'b1, 4'hE, 4'd6, 36'hFFFFFFFFF, 36'hFFFFC0000, 36'h05A,    36'hCCC,      36'hFFFFC0000, 1'b1};
      vt[12] = '{1'b1, 4'h0, 4'd6, 36'h0,         1'b1, 4'h0, 4'd6, 36'h0,        36'hFFFFC0000, 36'hFFFFC0000, 36'hFFFFC0000, 36'hFFFFC0000, 1'b0};
      vt[13] = '{1'b1, 4'h0, 4'd3, 36'h0,         1'b0, 4'h0, 4'd6, 36'h0,        36'h222,      36'h222,      36'h222,      36'hFFFFC0000, 1'b0};
      vt[14] = '{1'b0, 4'hF, 4'd0, 36'h999,       1'b0, 4'hF, 4'd0, 36'h999,      36'h222,      36'h222,      36'h222,      36'hFFFFC0000, 1'b0};

      rst = 1'b1; ena = 1'b0; enb = 1'b0; regcea = 1'b1; regceb = 1'b1;
      wea = '0; web = '0; addra = '0; addrb = '0; dia = '0; dib = '0;
      @(negedge clk);

      // Reset state
      chk("rst busy", {35'd0, busy_w[0]}, 36'd1);
      chk("rst doa", doa_w[0], 36'h0);
      chk("rst dob", dob_w[0], 36'h0);
      chk("rst col", {35'd0, col_w[0]}, 36'd0);
      chk("rst doa_reg", doa_w[3], 36'h0);

      // Clear length, with a write attempt held during the clear
      rst = 1'b0;
      ena = 1'b1; wea = 4'hF; addra = 4'd3; dia = 36'h123;
      count_busy(nb);
      ena = 1'b0; wea = '0; dia = '0;
      chk("clear cycles", 36'(nb), 36'd16);
      chk("clear doa held", doa_w[0], 36'h0);

      // Reset in the middle of the clear restarts it
      rst = 1'b1; tick(); rst = 1'b0;
      repeat (7) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      count_busy(nb);
      chk("restart clear cycles", 36'(nb), 36'd16);

      // Every word holds the clear value
      for (int a = 0; a < 16; a++) begin
         ena = 1'b1; addra = AW'(a);
         enb = 1'b1; addrb = AW'(15 - a);
         tick();
         chk($sformatf("clear word A%0d", a), doa_w[0], 36'h05A);
         chk($sformatf("clear word B%0d", 15 - a), dob_w[0], 36'h05A);
      end
      ena = 1'b0; enb = 1'b0;

      // Write modes, byte enables and collisions
      for (int i = 0; i < 15; i++) begin
         ena = vt[i].ena; wea = vt[i].wea; addra = vt[i].addra; dia = vt[i].dia;
         enb = vt[i].enb; web = vt[i].web; addrb = vt[i].addrb; dib = vt[i].dib;
         tick();
         chk($sformatf("vec%0d doa_wf", i), doa_w[0], vt[i].exp_wf);
         chk($sformatf("vec%0d doa_rf", i), doa_w[1], vt[i].exp_rf);
         chk($sformatf("vec%0d doa_nc", i), doa_w[2], vt[i].exp_nc);
         chk($sformatf("vec%0d dob", i), dob_w[0], vt[i].exp_dob);
         chk($sformatf("vec%0d col", i), {35'd0, col_w[0]}, {35'd0, vt[i].exp_col});
      end
      ena = 1'b0; enb = 1'b0; wea = '0; web = '0;

      // Output register: prime with mem[3], then read mem[2]
      ena = 1'b1; addra = 4'd3; regcea = 1'b1; tick();
      ena = 1'b0; tick();
      chk("doreg prime", doa_w[3], 36'h222);
      ena = 1'b1; addra = 4'd2; regcea = 1'b1; tick();
      chk("doreg lat1 unreg", doa_w[0], 36'h05A);
      chk("doreg not yet", doa_w[3], 36'h222);
      ena = 1'b0; regcea = 1'b0; tick();
      chk("doreg regce0 hold", doa_w[3], 36'h222);
      regcea = 1'b1; tick();
      chk("doreg regce1 load", doa_w[3], 36'h05A);
      ena = 1'b1; addra = 4'd3; tick();
      ena = 1'b0; tick();
      chk("doreg lat2", doa_w[3], 36'h222);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
